jk_bank_sequencer: RTL and testbench
====================================

Name: jk_bank_sequencer

Overview:
- Command-driven controller for a bank of WIDTH jkff instances.
- Accepts one command at a time over a valid/ready handshake: op, bit mask and edge count.
- Drives registered j/k vectors into the bank for the requested number of clock edges.
- Tracks the expected bank state internally and, after each command, checks the bank's q feedback against it, raising a sticky mismatch flag on any difference.
- Sits between a test/config master and the jkff bank; it shares the bank's clk and rst.

Parameters:
- WIDTH, 4, number of jkff instances in the driven bank.
- CNT_W, 4, width of the command edge-count field.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_op  input  2  operation: 00 HOLD, 01 CLEAR, 10 SET, 11 TOGGLE.
- cmd_mask  input  WIDTH  bits the operation applies to.
- cmd_len  input  CNT_W  number of clock edges to drive; a value of 0 is treated as 1.
- j  output  WIDTH  J inputs to the bank.
- k  output  WIDTH  K inputs to the bank.
- q_fb  input  WIDTH  q outputs from the bank.
- exp_q  output  WIDTH  expected bank state.
- busy  output  1  command in progress.
- done  output  1  one-cycle pulse when a command completes.
- mismatch  output  1  sticky compare-failure flag.

Behaviour:
- Reset (async, takes effect immediately, including mid-command):
  - state goes to IDLE.
  - j, k, exp_q, mismatch, busy, done, and the internal counter all go to 0.
  - cmd_ready is 0 while rst is high.
- States: IDLE, DRIVE, CHECK.
  - cmd_ready = (state==IDLE) & ~rst.
  - busy = (state!=IDLE).
- IDLE:
  - j=k=0.
  - On cmd_valid & cmd_ready at a rising edge: latch op and mask; load cnt = max(cmd_len,1)-1; go to DRIVE.
  - In the same edge, register j/k for the command so they are valid in the first DRIVE cycle.
- Op encoding, applied to masked bits only (unmasked bits get j=k=0):
  - HOLD: j=0, k=0.
  - CLEAR: j=0, k=1.
  - SET: j=1, k=0.
  - TOGGLE: j=1, k=1.
- DRIVE:
  - j/k are held constant.
  - Every rising edge in DRIVE updates exp_q by the JK equation (q' = j&~q | ~k&q) per bit.
  - If cnt==0: register j=k=0 and go to CHECK. Otherwise cnt decrements.
  - The bank therefore sees exactly max(cmd_len,1) edges with the command's j/k applied.
- CHECK (exactly one cycle):
  - done=1 (combinational from state); j=k=0.
  - At the closing edge: if q_fb != exp_q, set mismatch=1. Go to IDLE.
- mismatch is sticky and clears only on rst.
- cmd_valid while busy is ignored (not accepted, not queued); the master must hold it until cmd_ready.
- Throughput: one command per max(cmd_len,1)+2 cycles. The accept edge to the first j/k-applied edge is 1 cycle.
- HOLD still runs the DRIVE/CHECK sequence, so it can be used as a pure compare command.
- CNT_W wrap: cmd_len all-ones gives 2^CNT_W-1 edges; the counter never underflows.

Decomposition:
- Shared package jk_pkg:
  - op localparams OP_HOLD, OP_CLEAR, OP_SET, OP_TOGGLE.
  - state encodings ST_IDLE, ST_DRIVE, ST_CHECK.
- One sub-module: jk_next, a combinational per-vector JK next-state (inputs j, k, q; output q_next).
  - It is used for the exp_q update and is reusable by the bench's scoreboard.
- The jkff bank itself stays outside this block; the bench instantiates WIDTH jkff instances tied to j, k and q_fb.

Test Plan (WIDTH=4, CNT_W=4, jkff bank attached):
- Reset: assert rst 10 ns mid-clock -> j=k=0000, exp_q=0000, mismatch=0, busy=0, cmd_ready=0; after release cmd_ready=1.
- SET, mask 0101, len 1 -> j=0101, k=0000 for exactly 1 cycle; exp_q=q_fb=0101; done pulses on the 3rd cycle after accept; mismatch=0.
- TOGGLE, mask 1111, len 3, from 0101 -> j=k=1111 for 3 cycles; exp_q=q_fb=1010. Then CLEAR, mask 0011, len 0 -> exactly 1 drive cycle; exp_q=1000.
- Back-to-back: cmd_valid held high with SET 1111 len 2 while busy -> accepted only when cmd_ready returns; the command runs once and exp_q=1111.
- Fault: force q_fb[0]=1 during CLEAR, mask 0001, len 1 -> mismatch=1 after CHECK; it stays 1 through a following HOLD command and clears only on rst.
- Reset mid-DRIVE: TOGGLE, mask 1111, len 8, assert rst in the 3rd DRIVE cycle -> j=k=0000 immediately; state IDLE; exp_q=0000; no done pulse.

Source files
------------

// File: rtl/jk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jk_pkg
// Description : Shared op and state encodings for the JK bank sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package jk_pkg;

    localparam logic [1:0] OP_HOLD   = 2'b00;
    localparam logic [1:0] OP_CLEAR  = 2'b01;
    localparam logic [1:0] OP_SET    = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/jk_next.sv
`default_nettype none
// ============================================================================
// Module      : jk_next
// Description : Combinational per-bit JK flip-flop next-state vector.
// Revision    : 1.0 - initial release
// ============================================================================
module jk_next #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_next
);

    assign q_next = (j & ~q) | (~k & q);

endmodule
`default_nettype wire

// File: rtl/jk_bank_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : jk_bank_sequencer
// Description : Command-driven j/k sequencer for a jkff bank with an internal
//               expected-state model and a sticky q feedback compare.
// Revision    : 1.0 - initial release
// ============================================================================
module jk_bank_sequencer
    import jk_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [CNT_W-1:0] cmd_len,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] exp_q,
    output logic             busy,
    output logic             done,
    output logic             mismatch
);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [WIDTH-1:0] r_j;
    logic [WIDTH-1:0] r_k;
    logic [WIDTH-1:0] w_j_next;
    logic [WIDTH-1:0] w_k_next;
    logic [WIDTH-1:0] r_exp_q;
    logic [WIDTH-1:0] w_exp_next;
    logic [WIDTH-1:0] w_q_model;
    logic             r_mismatch;
    logic             w_mismatch_next;
    logic [WIDTH-1:0] w_cmd_j;
    logic [WIDTH-1:0] w_cmd_k;
    logic             w_accept;

    assign cmd_ready = (r_state == ST_IDLE) & ~rst;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_CHECK);
    assign j         = r_j;
    assign k         = r_k;
    assign exp_q     = r_exp_q;
    assign mismatch  = r_mismatch;
    assign w_accept  = cmd_valid & cmd_ready;

    // Model of the bank, advanced with the same j/k the bank sees each edge.
    jk_next #(
        .WIDTH (WIDTH)
    ) u_jk_next (
        .j      (r_j),
        .k      (r_k),
        .q      (r_exp_q),
        .q_next (w_q_model)
    );

    always_comb begin
        w_cmd_j = '0;
        w_cmd_k = '0;
        case (cmd_op)
            OP_CLEAR:  w_cmd_k = cmd_mask;
            OP_SET:    w_cmd_j = cmd_mask;
            OP_TOGGLE: begin
                w_cmd_j = cmd_mask;
                w_cmd_k = cmd_mask;
            end
            default: begin
                w_cmd_j = '0;
                w_cmd_k = '0;
            end
        endcase
    end

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_j_next        = r_j;
        w_k_next        = r_k;
        w_exp_next      = r_exp_q;
        w_mismatch_next = r_mismatch;
        case (r_state)
            ST_IDLE: begin
                w_j_next = '0;
                w_k_next = '0;
                if (w_accept) begin
                    w_state_next = ST_DRIVE;
                    // A zero length still drives one edge.
                    w_cnt_next   = (cmd_len == '0) ? '0 : (cmd_len - CNT_W'(1));
                    w_j_next     = w_cmd_j;
                    w_k_next     = w_cmd_k;
                end
            end
            ST_DRIVE: begin
                w_exp_next = w_q_model;
                if (r_cnt == '0) begin
                    w_j_next     = '0;
                    w_k_next     = '0;
                    w_state_next = ST_CHECK;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            ST_CHECK: begin
                w_j_next     = '0;
                w_k_next     = '0;
                w_state_next = ST_IDLE;
                if (q_fb != r_exp_q) begin
                    w_mismatch_next = 1'b1;
                end
            end
            default: begin
                w_j_next     = '0;
                w_k_next     = '0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_exp_q    <= '0;
            r_mismatch <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_j        <= w_j_next;
            r_k        <= w_k_next;
            r_exp_q    <= w_exp_next;
            r_mismatch <= w_mismatch_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_bank_sequencer
// Description : Directed vector bench for jk_bank_sequencer with a jkff bank.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_bank_sequencer;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [WIDTH-1:0] cmd_mask = '0;
    logic [CNT_W-1:0] cmd_len = '0;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] exp_q;
    logic             busy;
    logic             done;
    logic             mismatch;

    logic [WIDTH-1:0] bank_q;
    logic [WIDTH-1:0] force_one = '0;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // jkff bank, one flop per bit, sharing clk/rst with the sequencer
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bank
        always_ff @(posedge clk or posedge rst) begin
            if (rst) bank_q[gi] <= 1'b0;
            else     bank_q[gi] <= (j[gi] & ~bank_q[gi]) | (~k[gi] & bank_q[gi]);
        end
    end
    assign q_fb = bank_q | force_one;

    jk_bank_sequencer #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_mask  (cmd_mask),
        .cmd_len   (cmd_len),
        .j         (j),
        .k         (k),
        .q_fb      (q_fb),
        .exp_q     (exp_q),
        .busy      (busy),
        .done      (done),
        .mismatch  (mismatch)
    );

    typedef struct {
        logic [1:0]       op;
        logic [WIDTH-1:0] mask;
        logic [CNT_W-1:0] len;
        int               n_drive;
        logic [WIDTH-1:0] q_after;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Hand-written op table: expected j and k for the masked bits.
    function automatic logic [WIDTH-1:0] exp_j(input logic [1:0] op, input logic [WIDTH-1:0] m);
        return (op == 2'b10 || op == 2'b11) ? m : '0;
    endfunction
    function automatic logic [WIDTH-1:0] exp_k(input logic [1:0] op, input logic [WIDTH-1:0] m);
        return (op == 2'b01 || op == 2'b11) ? m : '0;
    endfunction

    // Present a command and return at the negedge of the first DRIVE cycle.
    task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] m, input logic [CNT_W-1:0] len);
        int guard;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_mask  = m;
        cmd_len   = len;
        guard     = 0;
        while (!cmd_ready && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) begin
            n_vec++;
            n_fail++;
            $display("FAIL send_timeout: cmd_ready stayed 0, expected 1");
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Check drive window, the CHECK cycle and the following IDLE cycle.
    task automatic check_run(input string name, input logic [1:0] op, input logic [WIDTH-1:0] m,
                             input int n_drive, input logic [WIDTH-1:0] q_after, input logic mm);
        for (int c = 0; c < n_drive; c++) begin
            chk({name, "_j"}, 32'(j), 32'(exp_j(op, m)));
            chk({name, "_k"}, 32'(k), 32'(exp_k(op, m)));
            chk({name, "_busy_done"}, {30'd0, busy, done}, 32'b10);
            @(negedge clk);
        end
        chk({name, "_chk_done"}, {30'd0, busy, done}, 32'b11);
        chk({name, "_chk_jk"}, {24'd0, j, k}, 32'd0);
        chk({name, "_chk_expq"}, 32'(exp_q), 32'(q_after));
        @(negedge clk);
        chk({name, "_idle"}, {29'd0, busy, done, cmd_ready}, 32'b001);
        chk({name, "_expq"}, 32'(exp_q), 32'(q_after));
        chk({name, "_qfb"}, 32'(q_fb), 32'(q_after | force_one));
        chk({name, "_mismatch"}, 32'(mismatch), 32'(mm));
    endtask

    initial begin
        int waited;

        //            op     mask     len    n   q after
        vecs[0] = '{2'b10, 4'b0101, 4'd1,  1,  4'b0101};
        vecs[1] = '{2'b11, 4'b1111, 4'd3,  3,  4'b1010};
        vecs[2] = '{2'b01, 4'b0011, 4'd0,  1,  4'b1000};
        vecs[3] = '{2'b00, 4'b1111, 4'd2,  2,  4'b1000};
        vecs[4] = '{2'b11, 4'b0110, 4'd15, 15, 4'b1110};
        vecs[5] = '{2'b10, 4'b0001, 4'd4,  4,  4'b1111};
        vecs[6] = '{2'b01, 4'b1111, 4'd2,  2,  4'b0000};

        // Reset asserted from time 0, released mid-clock
        #7;
        chk("rst_jk", {24'd0, j, k}, 32'd0);
        chk("rst_flags", {28'd0, busy, done, mismatch, cmd_ready}, 32'd0);
        chk("rst_expq", 32'(exp_q), 32'd0);
        #5 rst = 1'b0;
        #1;
        chk("rst_release_ready", 32'(cmd_ready), 32'd1);

        for (int v = 0; v < 7; v++) begin
            send(vecs[v].op, vecs[v].mask, vecs[v].len);
            check_run($sformatf("vec%0d", v), vecs[v].op, vecs[v].mask,
                      vecs[v].n_drive, vecs[v].q_after, 1'b0);
        end

        // Back-to-back: second command held valid while the first is busy
        send(2'b00, 4'b0000, 4'd3);
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_mask  = 4'b1111;
        cmd_len   = 4'd2;
        waited    = 0;
        while (!cmd_ready && waited < 64) begin
            chk("b2b_jk_hold", {24'd0, j, k}, 32'd0);
            @(negedge clk);
            waited++;
        end
        chk("b2b_wait_cycles", 32'(waited), 32'd4);
        @(negedge clk);
        cmd_valid = 1'b0;
        check_run("b2b", 2'b10, 4'b1111, 2, 4'b1111, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("b2b_no_repeat", {31'd0, busy}, 32'd0);
        end

        // Fault: bank bit0 stuck high while clearing it
        force_one = 4'b0001;
        send(2'b01, 4'b0001, 4'd1);
        check_run("fault", 2'b01, 4'b0001, 1, 4'b1110, 1'b1);
        force_one = 4'b0000;
        send(2'b00, 4'b0000, 4'd1);
        check_run("sticky", 2'b00, 4'b0000, 1, 4'b1110, 1'b1);

        // Reset in the third DRIVE cycle of a long toggle
        send(2'b11, 4'b1111, 4'd8);
        @(negedge clk);
        @(negedge clk);
        chk("mid_pre_busy", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_jk", {24'd0, j, k}, 32'd0);
        chk("mid_rst_flags", {28'd0, busy, done, mismatch, cmd_ready}, 32'd0);
        chk("mid_rst_expq", 32'(exp_q), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("mid_no_done", {30'd0, busy, done}, 32'd0);
        end
        chk("mid_ready", 32'(cmd_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
